// File: rtl/ioctl_dma_if.sv
// Write-request bus between ioctl_dma and the SDRAM arbiter.
// The request side holds mem_req/mem_addr/mem_din stable until mem_ack.
interface ioctl_dma_if;
   logic        mem_req;
   logic [24:0] mem_addr;
   logic [7:0]  mem_din;
   logic        mem_ack;

   modport master (
      output mem_req,
      output mem_addr,
      output mem_din,
      input  mem_ack
   );

   modport slave (
      input  mem_req,
      input  mem_addr,
      input  mem_din,
      output mem_ack
   );
endinterface

// File: rtl/ioctl_dma.sv
// ioctl_dma: turns the SPI download byte stream into SDRAM write requests
// through a small FIFO, and can also zero-fill an address range.
// The FIFO absorbs bytes that arrive while the arbiter is slow.
// A byte that arrives while the FIFO is full is dropped, and the
// sticky overflow flag is set.
module ioctl_dma #(
   parameter int FIFO_AW = 3
) (
   input  logic        clk_sys,
   input  logic        cold_reset,
   input  logic        ioctl_download,
   input  logic        ioctl_wr,
   input  logic [24:0] ioctl_addr,
   input  logic [7:0]  ioctl_dout,
   input  logic        erase_req,
   input  logic [24:0] erase_base,
   input  logic [24:0] erase_len,
   ioctl_dma_if.master mem,
   output logic        busy,
   output logic        done,
   output logic        overflow,
   output logic [24:0] last_addr
);

   localparam int DEPTH = 2 ** FIFO_AW;
   localparam logic [FIFO_AW:0] FULL_CNT = {1'b1, {FIFO_AW{1'b0}}};

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_DL    = 3'd1,
      S_FLUSH = 3'd2,
      S_ERASE = 3'd3,
      S_DONE  = 3'd4
   } state_t;

   state_t              state_r;
   logic                wr_d_r;
   logic                dl_d_r;
   logic                dl_pend_r;
   logic                mem_req_r;
   logic [24:0]         mem_addr_r;
   logic [7:0]          mem_din_r;
   logic                busy_r;
   logic                done_r;
   logic                overflow_r;
   logic [24:0]         last_addr_r;
   logic [24:0]         erase_addr_r;
   logic [24:0]         erase_rem_r;

   // FIFO entries are {addr[24:0], data[7:0]}
   logic [32:0]         fifo_mem [DEPTH];
   logic [FIFO_AW-1:0]  wr_ptr_r;
   logic [FIFO_AW-1:0]  rd_ptr_r;
   logic [FIFO_AW:0]    count_r;

   logic                wr_rise_s;
   logic                dl_rise_s;
   logic                dl_fall_s;
   logic                push_req_s;
   logic                full_s;
   logic                empty_s;
   logic                push_s;
   logic                pop_s;
   logic [32:0]         head_s;

   // Edge detection and FIFO control. The edge registers are cleared by
   // reset, so a strobe or download that is already high when reset is
   // released still counts as a rising edge.
   assign wr_rise_s  = ioctl_wr & ~wr_d_r;
   assign dl_rise_s  = ioctl_download & ~dl_d_r;
   assign dl_fall_s  = ~ioctl_download & dl_d_r;
   assign push_req_s = wr_rise_s & ioctl_download;
   assign full_s     = (count_r == FULL_CNT);
   assign empty_s    = (count_r == {(FIFO_AW + 1){1'b0}});
   assign push_s     = push_req_s & ~full_s;
   assign pop_s      = mem_req_r & mem.mem_ack &
                       ((state_r == S_DL) | (state_r == S_FLUSH));
   assign head_s     = fifo_mem[rd_ptr_r];

   assign mem.mem_req  = mem_req_r;
   assign mem.mem_addr = mem_addr_r;
   assign mem.mem_din  = mem_din_r;
   assign busy         = busy_r;
   assign done         = done_r;
   assign overflow     = overflow_r;
   assign last_addr    = last_addr_r;

   // Edge-detect history of the strobe and the download window
   always_ff @(posedge clk_sys or posedge cold_reset) begin
      if (cold_reset) begin
         wr_d_r <= 1'b0;
         dl_d_r <= 1'b0;
      end else begin
         wr_d_r <= ioctl_wr;
         dl_d_r <= ioctl_download;
      end
   end

   // FIFO storage; contents are don't-care while the FIFO is empty
   always_ff @(posedge clk_sys) begin
      if (push_s) begin
         fifo_mem[wr_ptr_r] <= {ioctl_addr, ioctl_dout};
      end
   end

   // FIFO pointers and occupancy; a push and a pop together leave the count unchanged
   always_ff @(posedge clk_sys or posedge cold_reset) begin
      if (cold_reset) begin
         wr_ptr_r <= {FIFO_AW{1'b0}};
         rd_ptr_r <= {FIFO_AW{1'b0}};
         count_r  <= {(FIFO_AW + 1){1'b0}};
      end else begin
         if (push_s) begin
            wr_ptr_r <= wr_ptr_r + FIFO_AW'(1'b1);
         end
         if (pop_s) begin
            rd_ptr_r <= rd_ptr_r + FIFO_AW'(1'b1);
         end
         case ({push_s, pop_s})
            2'b10:   count_r <= count_r + (FIFO_AW + 1)'(1'b1);
            2'b01:   count_r <= count_r - (FIFO_AW + 1)'(1'b1);
            default: count_r <= count_r;
         endcase
      end
   end

   // Sticky overflow: set when a byte is dropped, cleared on a new download window
   always_ff @(posedge clk_sys or posedge cold_reset) begin
      if (cold_reset) begin
         overflow_r <= 1'b0;
      end else if (push_req_s && full_s) begin
         overflow_r <= 1'b1;
      end else if (dl_rise_s) begin
         overflow_r <= 1'b0;
      end else begin
         overflow_r <= overflow_r;
      end
   end

   // Main FSM with registered request, status and address outputs
   always_ff @(posedge clk_sys or posedge cold_reset) begin
      if (cold_reset) begin
         state_r      <= S_IDLE;
         dl_pend_r    <= 1'b0;
         mem_req_r    <= 1'b0;
         mem_addr_r   <= 25'd0;
         mem_din_r    <= 8'h00;
         busy_r       <= 1'b0;
         done_r       <= 1'b0;
         last_addr_r  <= 25'd0;
         erase_addr_r <= 25'd0;
         erase_rem_r  <= 25'd0;
      end else begin
         done_r <= 1'b0;
         // A new window that opens while another job is still running
         // waits here until DONE.
         if (dl_rise_s && (state_r != S_IDLE) && (state_r != S_DONE)) begin
            dl_pend_r <= 1'b1;
         end
         case (state_r)
            S_IDLE: begin
               if (dl_rise_s || dl_pend_r) begin
                  state_r   <= S_DL;
                  busy_r    <= 1'b1;
                  dl_pend_r <= 1'b0;
               end else if (erase_req) begin
                  busy_r <= 1'b1;
                  if (erase_len != 25'd0) begin
                     state_r      <= S_ERASE;
                     erase_addr_r <= erase_base;
                     erase_rem_r  <= erase_len;
                  end else begin
                     state_r <= S_DONE;
                     done_r  <= 1'b1;
                  end
               end else begin
                  state_r <= S_IDLE;
               end
            end

            S_DL, S_FLUSH: begin
               if (mem_req_r) begin
                  if (mem.mem_ack) begin
                     mem_req_r   <= 1'b0;
                     last_addr_r <= mem_addr_r;
                  end
               end else if (!empty_s) begin
                  mem_req_r  <= 1'b1;
                  mem_addr_r <= head_s[32:8];
                  mem_din_r  <= head_s[7:0];
               end
               if (state_r == S_DL) begin
                  if (dl_fall_s) begin
                     state_r <= S_FLUSH;
                  end
               end else if (empty_s && !mem_req_r) begin
                  state_r <= S_DONE;
                  done_r  <= 1'b1;
               end
            end

            S_ERASE: begin
               if (mem_req_r) begin
                  if (mem.mem_ack) begin
                     mem_req_r    <= 1'b0;
                     erase_addr_r <= erase_addr_r + 25'd1;
                     erase_rem_r  <= erase_rem_r - 25'd1;
                     if (erase_rem_r == 25'd1) begin
                        state_r <= S_DONE;
                        done_r  <= 1'b1;
                     end
                  end
               end else begin
                  mem_req_r  <= 1'b1;
                  mem_addr_r <= erase_addr_r;
                  mem_din_r  <= 8'h00;
               end
            end

            S_DONE: begin
               if (dl_rise_s || dl_pend_r) begin
                  state_r   <= S_DL;
                  busy_r    <= 1'b1;
                  dl_pend_r <= 1'b0;
               end else begin
                  state_r <= S_IDLE;
                  busy_r  <= 1'b0;
               end
            end

            default: begin
               state_r   <= S_IDLE;
               mem_req_r <= 1'b0;
               busy_r    <= 1'b0;
               dl_pend_r <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ioctl_dma.sv
// Directed self-checking bench for ioctl_dma.
// It covers a plain download, FIFO overflow, a long strobe, erase with
// address wrap, a zero-length erase, reset during an erase, and an erase
// request that collides with the start of a download.
module tb_ioctl_dma;

   logic        clk_sys;
   logic        cold_reset;
   logic        ioctl_download;
   logic        ioctl_wr;
   logic [24:0] ioctl_addr;
   logic [7:0]  ioctl_dout;
   logic        erase_req;
   logic [24:0] erase_base;
   logic [24:0] erase_len;
   logic        busy;
   logic        done;
   logic        overflow;
   logic [24:0] last_addr;

   int total;
   int bad;

   ioctl_dma_if mem_bus ();

   ioctl_dma #(.FIFO_AW(3)) dut (
      .clk_sys        (clk_sys),
      .cold_reset     (cold_reset),
      .ioctl_download (ioctl_download),
      .ioctl_wr       (ioctl_wr),
      .ioctl_addr     (ioctl_addr),
      .ioctl_dout     (ioctl_dout),
      .erase_req      (erase_req),
      .erase_base     (erase_base),
      .erase_len      (erase_len),
      .mem            (mem_bus),
      .busy           (busy),
      .done           (done),
      .overflow       (overflow),
      .last_addr      (last_addr)
   );

   initial begin
      clk_sys = 1'b0;
      forever #5 clk_sys = ~clk_sys;
   end

   task automatic tick();
      @(posedge clk_sys);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic strobe(input logic [24:0] a, input logic [7:0] d, input int len);
      ioctl_addr = a;
      ioctl_dout = d;
      ioctl_wr   = 1'b1;
      repeat (len) tick();
      ioctl_wr   = 1'b0;
      tick();
   endtask

   task automatic wait_req();
      int n;
      n = 0;
      while (mem_bus.mem_req !== 1'b1 && n < 50) begin
         tick();
         n++;
      end
      chk("req_seen", 32'(mem_bus.mem_req), 32'd1);
   endtask

   // Wait for a request, check it, hold for dly cycles, then acknowledge it.
   task automatic service(input logic [24:0] ea, input logic [7:0] ed, input int dly);
      wait_req();
      chk("req_addr", 32'(mem_bus.mem_addr), 32'(ea));
      chk("req_data", 32'(mem_bus.mem_din), 32'(ed));
      repeat (dly) tick();
      chk("hold_req", 32'(mem_bus.mem_req), 32'd1);
      chk("hold_addr", 32'(mem_bus.mem_addr), 32'(ea));
      chk("hold_data", 32'(mem_bus.mem_din), 32'(ed));
      mem_bus.mem_ack = 1'b1;
      tick();
      mem_bus.mem_ack = 1'b0;
      chk("req_drop", 32'(mem_bus.mem_req), 32'd0);
   endtask

   task automatic wait_done(input logic exp_busy);
      int n;
      n = 0;
      while (done !== 1'b1 && n < 40) begin
         tick();
         n++;
      end
      chk("done_seen", 32'(done), 32'd1);
      tick();
      chk("done_once", 32'(done), 32'd0);
      chk("busy_after_done", 32'(busy), 32'(exp_busy));
   endtask

   initial begin
      total          = 0;
      bad            = 0;
      cold_reset     = 1'b1;
      ioctl_download = 1'b0;
      ioctl_wr       = 1'b0;
      ioctl_addr     = 25'd0;
      ioctl_dout     = 8'h00;
      erase_req      = 1'b0;
      erase_base     = 25'd0;
      erase_len      = 25'd0;
      mem_bus.mem_ack = 1'b0;

      // Reset state
      repeat (2) tick();
      chk("rst_req", 32'(mem_bus.mem_req), 32'd0);
      chk("rst_addr", 32'(mem_bus.mem_addr), 32'd0);
      chk("rst_din", 32'(mem_bus.mem_din), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_ovf", 32'(overflow), 32'd0);
      chk("rst_last", 32'(last_addr), 32'd0);
      cold_reset = 1'b0;
      tick();

      // Three-byte download, checking the two-cycle write latency
      ioctl_download = 1'b1;
      tick();
      chk("dl_busy", 32'(busy), 32'd1);
      ioctl_addr = 25'h0400000;
      ioctl_dout = 8'hA5;
      ioctl_wr   = 1'b1;
      tick();
      ioctl_wr = 1'b0;
      chk("lat_cycle1", 32'(mem_bus.mem_req), 32'd0);
      tick();
      chk("lat_cycle2", 32'(mem_bus.mem_req), 32'd1);
      strobe(25'h0400001, 8'h5A, 1);
      strobe(25'h0400002, 8'hFF, 1);
      service(25'h0400000, 8'hA5, 2);
      service(25'h0400001, 8'h5A, 2);
      service(25'h0400002, 8'hFF, 2);
      chk("dl_no_early_done", 32'(done), 32'd0);
      ioctl_download = 1'b0;
      wait_done(1'b0);
      chk("dl_last_addr", 32'(last_addr), 32'h0400002);

      // Overflow: ten strobes into an eight-entry FIFO with acks withheld
      ioctl_download = 1'b1;
      tick();
      chk("ovf_start", 32'(overflow), 32'd0);
      for (int i = 0; i < 10; i++) begin
         strobe(25'h0000100 + 25'(i), 8'h10 + 8'(i), 1);
      end
      chk("ovf_set", 32'(overflow), 32'd1);
      chk("ovf_head_addr", 32'(mem_bus.mem_addr), 32'h100);
      for (int i = 0; i < 8; i++) begin
         service(25'h0000100 + 25'(i), 8'h10 + 8'(i), 1);
      end
      repeat (4) tick();
      chk("ovf_no_ninth", 32'(mem_bus.mem_req), 32'd0);
      ioctl_download = 1'b0;
      wait_done(1'b0);
      chk("ovf_sticky", 32'(overflow), 32'd1);
      chk("ovf_last_addr", 32'(last_addr), 32'h107);
      ioctl_download = 1'b1;
      tick();
      chk("ovf_cleared", 32'(overflow), 32'd0);

      // Long strobe: one six-cycle strobe gives a single write
      strobe(25'h0000200, 8'h77, 6);
      service(25'h0000200, 8'h77, 1);
      repeat (6) tick();
      chk("long_single", 32'(mem_bus.mem_req), 32'd0);
      ioctl_download = 1'b0;
      wait_done(1'b0);
      chk("long_last_addr", 32'(last_addr), 32'h200);

      // Erase that wraps across the top of the address space
      erase_base = 25'h1FFFFFE;
      erase_len  = 25'd4;
      erase_req  = 1'b1;
      tick();
      erase_req = 1'b0;
      chk("erase_busy", 32'(busy), 32'd1);
      service(25'h1FFFFFE, 8'h00, 2);
      service(25'h1FFFFFF, 8'h00, 2);
      service(25'h0000000, 8'h00, 2);
      service(25'h0000001, 8'h00, 2);
      wait_done(1'b0);
      chk("erase_no_extra", 32'(mem_bus.mem_req), 32'd0);

      // Zero-length erase: done on the next cycle, no request
      erase_len = 25'd0;
      erase_req = 1'b1;
      tick();
      erase_req = 1'b0;
      chk("erase0_done", 32'(done), 32'd1);
      chk("erase0_noreq", 32'(mem_bus.mem_req), 32'd0);
      tick();
      chk("erase0_done_off", 32'(done), 32'd0);
      chk("erase0_idle", 32'(busy), 32'd0);
      chk("erase0_noreq2", 32'(mem_bus.mem_req), 32'd0);

      // Reset while an erase request is held
      erase_base = 25'h0000050;
      erase_len  = 25'd3;
      erase_req  = 1'b1;
      tick();
      erase_req = 1'b0;
      wait_req();
      cold_reset = 1'b1;
      #1;
      chk("rstmid_req", 32'(mem_bus.mem_req), 32'd0);
      chk("rstmid_busy", 32'(busy), 32'd0);
      tick();
      cold_reset = 1'b0;
      tick();
      mem_bus.mem_ack = 1'b1;
      tick();
      mem_bus.mem_ack = 1'b0;
      chk("late_ack_busy", 32'(busy), 32'd0);
      chk("late_ack_req", 32'(mem_bus.mem_req), 32'd0);
      chk("late_ack_done", 32'(done), 32'd0);
      repeat (3) tick();
      chk("rstmid_quiet", 32'(mem_bus.mem_req), 32'd0);

      // Erase request colliding with the download rise, then a pending re-open during FLUSH
      erase_base     = 25'h0000300;
      erase_len      = 25'd2;
      erase_req      = 1'b1;
      ioctl_download = 1'b1;
      tick();
      erase_req = 1'b0;
      chk("coll_busy", 32'(busy), 32'd1);
      strobe(25'h0000400, 8'h3C, 1);
      ioctl_download = 1'b0;
      tick();
      ioctl_download = 1'b1;
      tick();
      service(25'h0000400, 8'h3C, 1);
      wait_done(1'b1);
      strobe(25'h0000401, 8'h3D, 1);
      service(25'h0000401, 8'h3D, 1);
      ioctl_download = 1'b0;
      wait_done(1'b0);
      chk("coll_last_addr", 32'(last_addr), 32'h401);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/ioctl_dma.md
IOCTL_DMA -- requirements
Module: ioctl_dma

Interface
REQ-001 Parameter: FIFO_AW, default 3, FIFO address width; depth = 2**FIFO_AW entries of {addr[24:0], data[7:0]}.
REQ-002 clk_sys  input  1  system clock (28 MHz domain).
REQ-003 cold_reset  input  1  reset: asynchronous, active-high.
REQ-004 ioctl_download  input  1  download window from the SPI data channel.
REQ-005 ioctl_wr  input  1  byte strobe; may be high for more than one clk_sys cycle.
REQ-006 ioctl_addr  input  25  target SDRAM byte address of the current byte.
REQ-007 ioctl_dout  input  8  current download byte.
REQ-008 erase_req  input  1  one-cycle pulse requesting a zero-fill.
REQ-009 erase_base  input  25  first address to zero-fill.
REQ-010 erase_len  input  25  number of bytes to zero-fill.
REQ-011 mem_req  output  1  write request to the SDRAM arbiter.
REQ-012 mem_addr  output  25  write address; valid while mem_req is high.
REQ-013 mem_din  output  8  write data; valid while mem_req is high.
REQ-014 mem_ack  input  1  one-cycle acknowledge; the write is complete.
REQ-015 busy  output  1  high in any state other than IDLE.
REQ-016 done  output  1  one-cycle pulse at the end of a download or erase.
REQ-017 overflow  output  1  sticky flag: a byte was dropped because the FIFO was full.
REQ-018 last_addr  output  25  address of the last byte written in the most recent download.

Function
REQ-019 States: IDLE, DL, FLUSH, ERASE, DONE.
REQ-020 Push: a FIFO push occurs on the clk_sys cycle following a 0->1 transition of ioctl_wr, provided ioctl_download is high.
- Each ioctl_wr assertion produces exactly one push, regardless of strobe length.
REQ-021 FIFO full on push: the byte is discarded, the FIFO is unchanged, and overflow is set.
REQ-022 Clearing overflow: overflow is cleared only on a rising edge of ioctl_download or on reset.
REQ-023 Simultaneous push and pop in the same cycle are both performed; the occupancy count is unchanged.
REQ-024 IDLE->DL: on a rising edge of ioctl_download; overflow is also cleared.
REQ-025 DL/FLUSH request: when the FIFO is non-empty and mem_req is low, the block asserts mem_req with the FIFO head on mem_addr/mem_din.
- Earliest assertion: the cycle after the push that made the FIFO non-empty.
REQ-026 Request hold: mem_req, mem_addr and mem_din are held stable until the cycle in which mem_ack is high.
- The FIFO pops in that cycle.
- mem_req is low in the following cycle, giving at least one idle cycle between requests.
REQ-027 mem_ack received while mem_req is low is ignored.
REQ-028 DL->FLUSH: on a falling edge of ioctl_download.
REQ-029 FLUSH->DONE: when the FIFO is empty and no request is outstanding.
REQ-030 last_addr: updated with mem_addr on every acknowledged DL/FLUSH write.
REQ-031 IDLE->ERASE: on erase_req with erase_len != 0.
- Latches erase_base into an address counter and erase_len into a remaining counter.
REQ-032 ERASE writes: issues writes of 8'h00 using the REQ-025/026 handshake.
- Address increments by 1 and remaining decrements by 1 per acknowledged write.
- Address arithmetic is 25-bit and wraps modulo 2^25.
REQ-033 ERASE->DONE: when remaining reaches 0 after an acknowledge.
REQ-034 IDLE->DONE: on erase_req with erase_len == 0; no memory request is issued.
REQ-035 Ignored erase_req: erase_req in any state other than IDLE is ignored (no queuing).
REQ-036 Priority in IDLE: a rising edge of ioctl_download in the same cycle as erase_req takes priority; erase_req is dropped.
REQ-037 DONE: done is high for exactly one cycle, then the state returns to IDLE.
REQ-038 A rising edge of ioctl_download during FLUSH is held pending and starts DL immediately after DONE.
REQ-039 Write latency: from ioctl_wr rising edge to mem_req high is 2 clk_sys cycles when the FIFO is empty and idle.

Reset
REQ-040 cold_reset asserted: state=IDLE and the FIFO is emptied (pointers and count = 0).
REQ-041 Output values while cold_reset is asserted:
- mem_req=0, mem_addr=0, mem_din=0
- busy=0, done=0, overflow=0, last_addr=0
- edge-detect registers=0
REQ-042 Reset mid-operation: mem_req drops asynchronously; any outstanding write is abandoned, and a subsequent mem_ack is ignored per REQ-027.

Verification
REQ-043 Single write: download of 3 bytes A5,5A,FF at 25'h400000..02, mem_ack 3 cycles after each mem_req.
- Required: 3 writes in order with the same addresses and data.
- done pulses once after the download falls; last_addr=25'h400002.
REQ-044 Overflow: FIFO_AW=3, 10 one-cycle strobes spaced 2 cycles apart, mem_ack withheld.
- Required: overflow=1.
- After ack release, exactly 8 writes with the first 8 bytes.
- The next download clears overflow.
REQ-045 Long strobe: ioctl_wr held high for 6 cycles.
- Required: exactly one push and one write.
REQ-046 Erase: erase_base=25'h1FFFFFE, erase_len=4.
- Required: zero writes at 1FFFFFE, 1FFFFFF, 0000000, 0000001, then done.
- erase_len=0 gives done on the next cycle with no mem_req.
REQ-047 Reset mid-erase: cold_reset asserted during a held mem_req.
- Required: mem_req=0 in the same cycle; busy=0; the FIFO is empty.
- A late mem_ack causes no state change.
REQ-048 Collision: erase_req coincident with the ioctl_download rise.
- Required: DL is entered and no zero writes are issued.
